// File: rtl/passcode_pkg.sv
// Shared key codes, blank nibble and controller state encoding for the passcode lock.
package passcode_pkg;
  localparam logic [4:0] KEY_ENTER  = 5'd10;
  localparam logic [4:0] KEY_CLEAR  = 5'd11;
  localparam logic [4:0] KEY_CHANGE = 5'd12;
  localparam logic [4:0] KEY_LOCK   = 5'd13;
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  typedef enum logic [2:0] {
    LOCKED, CHECK, OPEN, CHG_NEW, CHG_CONFIRM, LOCKOUT
  } state_t;

  function automatic logic is_digit(input logic [4:0] k);
    return k < 5'd10;
  endfunction
endpackage

// File: rtl/passcode_lock_ctrl_if.sv
// Keypad-in / indicator-out bundle of the passcode lock controller.
interface passcode_lock_ctrl_if #(parameter int DIGITS = 4);
  logic [4:0]          key_value;
  logic                key_ready;
  logic [4*DIGITS-1:0] disp_digits;
  logic [3:0]          digit_cnt;
  logic                unlocked;
  logic                locked_out;
  logic                chg_mode;
  logic [3:0]          tries_left;
  logic                ok_pulse;
  logic                err_pulse;

  modport master (output key_value, key_ready,
                  input  disp_digits, digit_cnt, unlocked, locked_out, chg_mode,
                         tries_left, ok_pulse, err_pulse);
  modport slave  (input  key_value, key_ready,
                  output disp_digits, digit_cnt, unlocked, locked_out, chg_mode,
                         tries_left, ok_pulse, err_pulse);
endinterface

// File: rtl/passcode_entry_buf.sv
// Digit shift buffer: newest digit lands in nibble 0; saturates at DIGITS entries.
module passcode_entry_buf
  import passcode_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                push,
  input  logic [3:0]          digit,
  output logic [4*DIGITS-1:0] digits,
  output logic [3:0]          cnt,
  output logic                full
);
  assign full = (cnt == 4'(DIGITS));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digits <= {DIGITS{BLANK_NIBBLE}};
      cnt    <= '0;
    end else if (push && !full) begin
      digits <= {digits[4*DIGITS-5:0], digit};
      cnt    <= cnt + 4'd1;
    end
  end
endmodule

// File: rtl/passcode_lock_ctrl.sv
// Passcode verify/store controller with retry lockout and two-step code change.
// Optional idle auto-relock of the open lock: define PASSCODE_AUTO_RELOCK_EN.
module passcode_lock_ctrl
  import passcode_pkg::*;
#(
  parameter int          DIGITS       = 4,
  parameter int          MAX_TRIES    = 3,
  parameter logic [31:0] LOCKOUT_CYC  = 32'd50_000_000,
  parameter logic [31:0] OPEN_CYC     = 32'd250_000_000,
  parameter logic [31:0] DEFAULT_CODE = 32'h0000_1234
) (
  input logic                  clk,
  input logic                  rst,
  passcode_lock_ctrl_if.slave  kp
);
  localparam int W = 4*DIGITS;

  // Zero-length timers would underflow on load, so reject them at elaboration.
  if (DIGITS < 2 || DIGITS > 8 || MAX_TRIES < 1 || MAX_TRIES > 15 ||
      LOCKOUT_CYC == 0 || OPEN_CYC == 0) begin : g_bad_cfg
    $error("passcode_lock_ctrl: parameter out of range");
  end

  state_t         state, state_nxt;
  logic [W-1:0]   stored, stored_nxt, cand, cand_nxt, entry;
  logic [3:0]     tries, tries_nxt, cnt;
  logic [31:0]    lo_cnt, lo_nxt;
  logic           full, buf_clr, buf_push, key_live;
  logic           ok_nxt, err_nxt, ok_q, err_q, unl_q, lo_q, chg_q;
`ifdef PASSCODE_AUTO_RELOCK_EN
  logic [31:0]    op_cnt, op_nxt;
`endif

  passcode_entry_buf #(.DIGITS(DIGITS)) u_buf (
    .clk(clk), .rst(rst), .clr(buf_clr), .push(buf_push),
    .digit(kp.key_value[3:0]), .digits(entry), .cnt(cnt), .full(full)
  );

  always_comb begin
    state_nxt  = state;
    stored_nxt = stored;
    cand_nxt   = cand;
    tries_nxt  = tries;
    lo_nxt     = lo_cnt;
    ok_nxt     = 1'b0;
    err_nxt    = 1'b0;
    // CHECK and LOCKOUT swallow keys; the other states share digit/CLEAR handling.
    key_live   = kp.key_ready && (state inside {LOCKED, OPEN, CHG_NEW, CHG_CONFIRM});
    buf_push   = key_live && is_digit(kp.key_value);
    buf_clr    = key_live && (kp.key_value == KEY_CLEAR);
    case (state)
      LOCKED: if (key_live && kp.key_value == KEY_ENTER) begin
        if (full) state_nxt = CHECK;
        else begin err_nxt = 1'b1; buf_clr = 1'b1; end
      end
      CHECK: begin
        buf_clr = 1'b1;
        if (entry == stored) begin
          ok_nxt = 1'b1; tries_nxt = 4'(MAX_TRIES); state_nxt = OPEN;
        end else begin
          err_nxt   = 1'b1;
          tries_nxt = tries - 4'd1;
          if (tries_nxt == 4'd0) begin
            state_nxt = LOCKOUT; lo_nxt = LOCKOUT_CYC - 32'd1;
          end else state_nxt = LOCKED;
        end
      end
      OPEN: if (key_live) begin
        if (kp.key_value == KEY_LOCK)        begin state_nxt = LOCKED;  buf_clr = 1'b1; end
        else if (kp.key_value == KEY_CHANGE) begin state_nxt = CHG_NEW; buf_clr = 1'b1; end
      end
      CHG_NEW: if (key_live && kp.key_value == KEY_ENTER) begin
        buf_clr = 1'b1;
        if (full) begin cand_nxt = entry; state_nxt = CHG_CONFIRM; end
        else err_nxt = 1'b1;
      end
      CHG_CONFIRM: if (key_live) begin
        if (kp.key_value == KEY_CLEAR) state_nxt = CHG_NEW;
        else if (kp.key_value == KEY_ENTER) begin
          buf_clr = 1'b1;
          if (!full) err_nxt = 1'b1;
          else begin
            if (entry == cand) begin stored_nxt = entry; ok_nxt = 1'b1; end
            else err_nxt = 1'b1;
            cand_nxt  = '0;
            state_nxt = OPEN;
          end
        end
      end
      LOCKOUT: begin
        buf_clr = 1'b1;
        if (lo_cnt == 32'd0) begin tries_nxt = 4'(MAX_TRIES); state_nxt = LOCKED; end
        else lo_nxt = lo_cnt - 32'd1;
      end
      default: state_nxt = LOCKED;
    endcase
`ifdef PASSCODE_AUTO_RELOCK_EN
    op_nxt = op_cnt;
    if (state inside {OPEN, CHG_NEW, CHG_CONFIRM}) begin
      if (kp.key_ready) op_nxt = OPEN_CYC - 32'd1;
      else if (op_cnt == 32'd0) begin
        state_nxt = LOCKED; buf_clr = 1'b1; cand_nxt = '0;
      end else op_nxt = op_cnt - 32'd1;
    end else if (state_nxt == OPEN) op_nxt = OPEN_CYC - 32'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOCKED;
      stored <= DEFAULT_CODE[W-1:0];
      cand   <= '0;
      tries  <= 4'(MAX_TRIES);
      lo_cnt <= '0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      unl_q  <= 1'b0;
      lo_q   <= 1'b0;
      chg_q  <= 1'b0;
`ifdef PASSCODE_AUTO_RELOCK_EN
      op_cnt <= '0;
`endif
    end else begin
      state  <= state_nxt;
      stored <= stored_nxt;
      cand   <= cand_nxt;
      tries  <= tries_nxt;
      lo_cnt <= lo_nxt;
      ok_q   <= ok_nxt;
      err_q  <= err_nxt;
      unl_q  <= state_nxt inside {OPEN, CHG_NEW, CHG_CONFIRM};
      lo_q   <= (state_nxt == LOCKOUT);
      chg_q  <= state_nxt inside {CHG_NEW, CHG_CONFIRM};
`ifdef PASSCODE_AUTO_RELOCK_EN
      op_cnt <= op_nxt;
`endif
    end
  end

  assign kp.disp_digits = entry;
  assign kp.digit_cnt   = cnt;
  assign kp.unlocked    = unl_q;
  assign kp.locked_out  = lo_q;
  assign kp.chg_mode    = chg_q;
  assign kp.tries_left  = tries;
  assign kp.ok_pulse    = ok_q;
  assign kp.err_pulse   = err_q;
endmodule
